radiant_scaler_readout: RTL and testbench
=========================================

# radiant_scaler_readout

Wishbone-master sequencer that drains the dual-packed scaler readback window into a framed 32-bit stream after each scaler update. It sits between the scaler block's slave port and the event/housekeeping stream. On a start pulse it emits one header word, then reads NUM_WORDS consecutive scaler words. Each word is forwarded over a valid/ready handshake, so the scaler block never needs software polling.

## Interface
Parameters:
- NUM_WORDS, 16: dual-scaler words read per frame, range 1–64.
- BASE_ADDR, 16'h0800: byte address of the first scaler word; subsequent words are at +4.
- TIMEOUT_CYCLES, 255: ack wait limit, 8-bit range. Used only with SCALER_READOUT_TIMEOUT_EN.

Ports:
- clk_i, in, 1: the single clock. Every flop is on its rising edge.
- rst_n_i, in, 1: asynchronous, active-low reset.
- start_i, in, 1: one-cycle pulse, driven by the scaler update-done or PPS.
- enable_i, in, 1: while low, start_i is ignored.
- wbm_cyc_o / wbm_stb_o, out, 1: Wishbone master cycle/strobe.
- wbm_we_o, out, 1: tied 0 (read only).
- wbm_adr_o, out, 16: byte address.
- wbm_sel_o, out, 4: tied 4'hF.
- wbm_dat_i, in, 32: read data.
- wbm_ack_i / wbm_err_i, in, 1: cycle termination.
- m_tdata, out, 32: stream data.
- m_tvalid, out, 1: stream valid.
- m_tready, in, 1: stream ready.
- m_tlast, out, 1: marks the last word of a frame.
- busy_o, out, 1: high whenever state is not IDLE.
- err_o, out, 1: sticky; set by a bus error or timeout. Cleared when the next frame is accepted.

## Operation
State machine:
- IDLE: wait for a start.
  - start_i && enable_i → HDR.
  - Latch missed_q into the header and clear it.
  - Clear err_o and set idx=0.
- HDR: present the header with m_tvalid=1.
  - Header = {8'hA5, 7'b0, missed, seq[7:0], 8'(NUM_WORDS)}.
  - On m_tready: seq increments (8-bit, wraps 255→0) and state → REQ.
- REQ: assert cyc/stb with wbm_adr_o = BASE_ADDR + 4·idx.
  - On ack: capture wbm_dat_i.
  - On err: capture 32'hFFFF_FFFF and set err_o.
  - Either termination → OUT, with cyc/stb low in the next cycle.
  - If ack and err arrive together, err wins.
- OUT: present the captured word with m_tvalid=1.
  - m_tlast = (idx == NUM_WORDS-1).
  - On m_tready: if last → IDLE, else idx++ and → REQ.

Other rules:
- Start pulses are accepted only in IDLE. A start_i with enable_i high in any other state sets missed_q.
  - This includes the cycle of the final handshake.
- Starts with enable_i low are dropped silently and do not set missed_q.
- enable_i falling mid-frame does not abort the frame in progress.
- m_tdata/m_tvalid/m_tlast are registered and held stable while m_tvalid && !m_tready.
- idx is 6 bits. wbm_adr_o is computed modulo 2^16.

## Timing
- Reset values: all outputs 0; state IDLE; seq=0; idx=0; missed_q=0; err_o=0.
- Start at cycle t: m_tvalid (header) is high at t+1.
- Header handshake at cycle h: cyc/stb are high at h+1.
- Ack at cycle a: m_tvalid with data at a+1, and cyc/stb low at a+1.
- Zero-wait slave with m_tready held high: a frame takes 1 + 2·NUM_WORDS cycles after the start cycle. busy_o falls the cycle after the last handshake.
- An asynchronous reset mid-frame:
  - Drops cyc/stb and m_tvalid immediately.
  - No partial frame resumes after reset release.

## Configuration
- SCALER_READOUT_TIMEOUT_EN defined:
  - An 8-bit counter runs in REQ.
  - If TIMEOUT_CYCLES cycles pass without ack/err: drop cyc/stb, capture 32'hDEAD_BEEF, set err_o, and go to OUT.
  - An ack in the same cycle as expiry takes priority over the timeout.
- Undefined: REQ waits indefinitely. No counter logic is synthesized.

## Test plan
- Basic frame: NUM_WORDS=4, zero-wait slave returning 32'h1000_0000+adr, m_tready=1.
  - Expected stream: A5000004, then 10000800, 10000804, 10000808, 1000080C, with m_tlast on the 5th word.
  - busy_o is high for 9 cycles.
- Backpressure: toggle m_tready randomly and insert 0–3 ack wait states.
  - Data stays stable while stalled. Word order and count are unchanged. Exactly one cyc/stb burst per word.
- Missed start: pulse start_i mid-frame and again on the last handshake cycle.
  - The next frame's header has bit 16=1 and seq=1. The following frame has bit 16=0.
- Bus error: assert wbm_err_i on word 2.
  - That word is FFFFFFFF and err_o=1. The frame completes, and err_o clears at the next accepted start.
- Timeout (macro defined, TIMEOUT_CYCLES=10): slave never acks word 0.
  - cyc/stb drop after 10 cycles, the word is DEADBEEF, and err_o=1.
  - Without the macro, busy_o stays high.
- Reset and wrap:
  - Assert rst_n_i mid-OUT: all outputs are 0 immediately.
  - After 256 frames, seq wraps to 00.
  - A start with enable_i=0 produces no frame and no missed flag.

Source files
------------

// File: rtl/radiant_scaler_readout_if.sv
// -----------------------------------------------------------------------------
// radiant_scaler_readout_if
//
// Bundles the two buses of the scaler readout sequencer:
//   - Wishbone read master towards the scaler block slave port
//       wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o[15:0], wbm_sel_o[3:0]  (master -> slave)
//       wbm_dat_i[31:0], wbm_ack_i, wbm_err_i                            (slave -> master)
//   - 32-bit valid/ready output stream towards the event/housekeeping path
//       m_tdata[31:0], m_tvalid, m_tlast                                 (master -> sink)
//       m_tready                                                         (sink -> master)
//
// Modports:
//   master : the sequencer side (drives Wishbone requests and stream data)
//   slave  : the far side (scaler slave + stream sink), used by a bench
// -----------------------------------------------------------------------------
interface radiant_scaler_readout_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [15:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output m_tdata, m_tvalid, m_tlast,
        input  m_tready
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_sel_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  m_tdata, m_tvalid, m_tlast,
        output m_tready
    );
endinterface

// File: rtl/radiant_scaler_readout.sv
// -----------------------------------------------------------------------------
// radiant_scaler_readout
//
// Wishbone-master sequencer that drains the dual-packed scaler readback window
// into a framed 32-bit stream. On an accepted start it emits one header word
//   {8'hA5, 7'b0, missed, seq[7:0], NUM_WORDS[7:0]}
// followed by NUM_WORDS words read from BASE_ADDR, BASE_ADDR+4, ... Each word is
// fetched with a single Wishbone read burst and then forwarded over valid/ready.
//
// Ports:
//   clk_i     : clock, all flops on the rising edge
//   rst_n_i   : asynchronous active-low reset
//   start_i   : one-cycle start pulse (scaler update-done / PPS)
//   enable_i  : start_i is ignored while low
//   bus       : radiant_scaler_readout_if.master (Wishbone master + stream out)
//   busy_o    : high whenever the sequencer is not idle
//   err_o     : sticky bus-error/timeout flag, cleared by the next accepted start
//
// Parameters:
//   NUM_WORDS      : words per frame, 1..64
//   BASE_ADDR      : byte address of the first scaler word
//   TIMEOUT_CYCLES : ack wait limit (1..255), only with SCALER_READOUT_TIMEOUT_EN
//
// Build option:
//   `define SCALER_READOUT_TIMEOUT_EN adds an ack-wait watchdog; without it a
//   read waits for ack/err indefinitely.
// -----------------------------------------------------------------------------
module radiant_scaler_readout #(
    parameter int unsigned NUM_WORDS      = 16,
    parameter logic [15:0] BASE_ADDR      = 16'h0800,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            start_i,
    input  logic                            enable_i,
    radiant_scaler_readout_if.master        bus,
    output logic                            busy_o,
    output logic                            err_o
);

    if (NUM_WORDS < 1 || NUM_WORDS > 64) begin : g_bad_num_words
        $error("radiant_scaler_readout: NUM_WORDS must be 1..64");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("radiant_scaler_readout: TIMEOUT_CYCLES must be 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_REQ,
        ST_OUT
    } state_t;

    localparam logic [5:0] LAST_IDX    = 6'(NUM_WORDS - 1);
    localparam logic [7:0] NUM_WORDS_B = 8'(NUM_WORDS);

    state_t      state_q,  state_d;
    logic [7:0]  seq_q,    seq_d;
    logic [5:0]  idx_q,    idx_d;
    logic        missed_q, missed_d;
    logic        err_q,    err_d;
    logic [31:0] tdata_q,  tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q,  tlast_d;
    logic        cyc_q,    cyc_d;
    logic [15:0] adr_q,    adr_d;

    logic start_ok;
    logic tmo_hit;

    assign start_ok = start_i & enable_i;

    // Byte address of scaler word idx; wraps modulo 2^16.
    function automatic logic [15:0] word_adr(input logic [5:0] idx);
        return BASE_ADDR + {8'd0, idx, 2'b00};
    endfunction

`ifdef SCALER_READOUT_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_q, tmo_d;

    // Counts cycles spent waiting in REQ; restarts from 0 on every entry.
    always_comb begin
        tmo_d = 8'd0;
        if (state_q == ST_REQ && !bus.wbm_ack_i && !bus.wbm_err_i) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    assign tmo_hit = (state_q == ST_REQ) && (tmo_q == TMO_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_q <= 8'd0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        idx_d    = idx_q;
        missed_d = missed_q;
        err_d    = err_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        cyc_d    = cyc_q;
        adr_d    = adr_q;

        // A start that arrives while a frame is still running (including the
        // cycle of its final handshake) is remembered for the next header.
        if (state_q != ST_IDLE && start_ok) begin
            missed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    tdata_d  = {8'hA5, 7'd0, missed_q, seq_q, NUM_WORDS_B};
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    missed_d = 1'b0;
                    err_d    = 1'b0;
                    idx_d    = 6'd0;
                    state_d  = ST_HDR;
                end
            end

            ST_HDR: begin
                if (bus.m_tready) begin
                    tvalid_d = 1'b0;
                    seq_d    = seq_q + 8'd1;
                    cyc_d    = 1'b1;
                    adr_d    = word_adr(idx_q);
                    state_d  = ST_REQ;
                end
            end

            ST_REQ: begin
                // Priority: err over ack, ack over watchdog expiry.
                if (bus.wbm_err_i || bus.wbm_ack_i || tmo_hit) begin
                    if (bus.wbm_err_i) begin
                        tdata_d = 32'hFFFF_FFFF;
                        err_d   = 1'b1;
                    end else if (bus.wbm_ack_i) begin
                        tdata_d = bus.wbm_dat_i;
                    end else begin
                        tdata_d = 32'hDEAD_BEEF;
                        err_d   = 1'b1;
                    end
                    cyc_d    = 1'b0;
                    tvalid_d = 1'b1;
                    tlast_d  = (idx_q == LAST_IDX);
                    state_d  = ST_OUT;
                end
            end

            ST_OUT: begin
                if (bus.m_tready) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    if (tlast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        cyc_d   = 1'b1;
                        adr_d   = word_adr(idx_q + 6'd1);
                        state_d = ST_REQ;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            seq_q    <= 8'd0;
            idx_q    <= 6'd0;
            missed_q <= 1'b0;
            err_q    <= 1'b0;
            tdata_q  <= 32'd0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            cyc_q    <= 1'b0;
            adr_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            idx_q    <= idx_d;
            missed_q <= missed_d;
            err_q    <= err_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            cyc_q    <= cyc_d;
            adr_q    <= adr_d;
        end
    end

    assign bus.wbm_cyc_o = cyc_q;
    assign bus.wbm_stb_o = cyc_q;
    assign bus.wbm_we_o  = 1'b0;
    assign bus.wbm_sel_o = 4'hF;
    assign bus.wbm_adr_o = adr_q;
    assign bus.m_tdata   = tdata_q;
    assign bus.m_tvalid  = tvalid_q;
    assign bus.m_tlast   = tlast_q;

    assign busy_o = (state_q != ST_IDLE);
    assign err_o  = err_q;

endmodule

// File: tb/tb_radiant_scaler_readout.sv
// -----------------------------------------------------------------------------
// tb_radiant_scaler_readout
//
// Drives radiant_scaler_readout (NUM_WORDS=4, BASE_ADDR=16'h0800,
// TIMEOUT_CYCLES=10) with a randomized Wishbone slave / stream sink and checks
// every frame against a frame-level model: header fields from a sequence count
// and a pending-missed flag, payload from the slave's address-derived data.
// -----------------------------------------------------------------------------
module tb_radiant_scaler_readout;
    localparam int          NW   = 4;
    localparam logic [15:0] BASE = 16'h0800;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start  = 1'b0;
    logic enable = 1'b0;
    logic busy;
    logic err;

    radiant_scaler_readout_if bus ();

    radiant_scaler_readout #(
        .NUM_WORDS      (NW),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .enable_i (enable),
        .bus      (bus.master),
        .busy_o   (busy),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fail_cnt  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Agent configuration and observations
    int  cfg_ready_pct = 100;
    int  cfg_max_wait  = 0;
    int  cfg_bad_word  = -1;
    int  cfg_bad_kind  = 0;   // 1: err, 2: never terminate, 3: ack+err together
    int  burst_cnt     = 0;
    int  burst0_len    = 0;
    int  tvalid_seen   = 0;
    logic [32:0] rx_q[$];

    // Frame-level reference state
    int  model_seq   = 0;
    bit  pend_missed = 1'b0;

    // Stream sink + Wishbone slave: decides inputs at each falling edge for the
    // following rising edge, and records stream handshakes.
    initial begin
        int          wait_left;
        int          cur_len;
        int          word;
        bit          in_burst;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        in_burst      = 1'b0;
        prev_stall    = 1'b0;
        prev_data     = 32'd0;
        prev_last     = 1'b0;
        wait_left     = 0;
        cur_len       = 0;
        bus.m_tready  = 1'b0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_err_i = 1'b0;
        bus.wbm_dat_i = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.m_tready  = 1'b0;
                bus.wbm_ack_i = 1'b0;
                bus.wbm_err_i = 1'b0;
                in_burst      = 1'b0;
                prev_stall    = 1'b0;
                continue;
            end
            bus.m_tready = (int'($urandom_range(99, 0)) < cfg_ready_pct);
            if (prev_stall) begin
                check_eq("stall_valid", 32'(bus.m_tvalid), 32'd1);
                check_eq("stall_data", bus.m_tdata, prev_data);
                check_eq("stall_last", 32'(bus.m_tlast), 32'(prev_last));
            end
            if (bus.m_tvalid) tvalid_seen++;
            if (bus.m_tvalid && bus.m_tready) rx_q.push_back({bus.m_tlast, bus.m_tdata});
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev_data  = bus.m_tdata;
            prev_last  = bus.m_tlast;

            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            if (bus.wbm_cyc_o) begin
                if (!in_burst) begin
                    in_burst  = 1'b1;
                    wait_left = int'($urandom_range(cfg_max_wait, 0));
                    cur_len   = 0;
                    check_eq("burst_adr", 32'(bus.wbm_adr_o), 32'(BASE + 16'(4 * burst_cnt)));
                    check_eq("burst_stb", 32'(bus.wbm_stb_o), 32'd1);
                    burst_cnt++;
                end
                cur_len++;
                if (burst_cnt == 1) burst0_len = cur_len;
                word = burst_cnt - 1;
                if (word == cfg_bad_word && cfg_bad_kind == 2) begin
                    // slave stays silent
                end else if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    bus.wbm_dat_i = 32'h1000_0000 + {16'h0, bus.wbm_adr_o};
                    if (word == cfg_bad_word && cfg_bad_kind == 1) begin
                        bus.wbm_err_i = 1'b1;
                    end else if (word == cfg_bad_word && cfg_bad_kind == 3) begin
                        bus.wbm_err_i = 1'b1;
                        bus.wbm_ack_i = 1'b1;
                    end else begin
                        bus.wbm_ack_i = 1'b1;
                    end
                end
            end else begin
                in_burst = 1'b0;
            end
        end
    end

    task automatic run_frame(input int ready_pct, input int max_wait, input int bad_word,
                             input int bad_kind, input bit mid_pulse, input bit mid_en,
                             input bit last_pulse, input int exp_busy);
        logic [31:0] exp_w;
        bit          exp_missed;
        int          busy_cnt;
        cfg_ready_pct = ready_pct;
        cfg_max_wait  = max_wait;
        cfg_bad_word  = bad_word;
        cfg_bad_kind  = bad_kind;
        @(negedge clk); #1;
        rx_q.delete();
        burst_cnt   = 0;
        exp_missed  = pend_missed;
        pend_missed = 1'b0;
        start  = 1'b1;
        enable = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        check_eq("hdr_valid_t1", 32'(bus.m_tvalid), 32'd1);
        check_eq("err_cleared", 32'(err), 32'd0);
        busy_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            if (!busy) break;
            busy_cnt++;
            start  = 1'b0;
            enable = 1'b1;
            if (mid_pulse && c == 3) begin
                start  = 1'b1;
                enable = mid_en;
                if (mid_en) pend_missed = 1'b1;
            end
            if (last_pulse && bus.m_tvalid && bus.m_tlast && bus.m_tready) begin
                start       = 1'b1;
                pend_missed = 1'b1;
            end
            @(negedge clk); #1;
        end
        start  = 1'b0;
        enable = 1'b1;
        check_eq("frame_done", 32'(busy), 32'd0);
        if (exp_busy > 0) check_eq("busy_len", 32'(busy_cnt), 32'(exp_busy));
        check_eq("rx_count", 32'(rx_q.size()), 32'(NW + 1));
        for (int i = 0; i <= NW && i < rx_q.size(); i++) begin
            if (i == 0) begin
                exp_w = {8'hA5, 7'd0, exp_missed, 8'(model_seq), 8'(NW)};
            end else begin
                exp_w = 32'h1000_0000 + 32'(BASE) + 32'(4 * (i - 1));
                if (i - 1 == bad_word) exp_w = (bad_kind == 2) ? 32'hDEAD_BEEF : 32'hFFFF_FFFF;
            end
            check_eq($sformatf("word%0d_seq%0d", i, model_seq), rx_q[i][31:0], exp_w);
            check_eq($sformatf("last%0d", i), 32'(rx_q[i][32]), 32'(i == NW));
        end
        check_eq("burst_cnt", 32'(burst_cnt), 32'(NW));
        check_eq("err_sticky", 32'(err), (bad_word >= 0) ? 32'd1 : 32'd0);
        $display("[TB] frame seq=%0d missed=%0d words=%0d busy=%0d", model_seq, exp_missed,
                 rx_q.size(), busy_cnt);
        model_seq = (model_seq + 1) % 256;
    endtask

    initial begin
        bit found;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_tvalid", 32'(bus.m_tvalid), 32'd0);
        check_eq("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_tdata", bus.m_tdata, 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (2) @(negedge clk);

        // Basic zero-wait frame
        run_frame(100, 0, -1, 0, 1'b0, 1'b0, 1'b0, 2 * NW + 1);

        // Random backpressure and wait states
        for (int k = 0; k < 12; k++) run_frame(60, 3, -1, 0, 1'b0, 1'b0, 1'b0, 0);

        // Missed start mid-frame, then on the final handshake
        run_frame(100, 0, -1, 0, 1'b1, 1'b1, 1'b0, 0);
        run_frame(100, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0);
        run_frame(100, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0);
        run_frame(70, 2, -1, 0, 1'b0, 1'b0, 1'b1, 0);
        run_frame(100, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0);

        // Start with enable low mid-frame: not missed, frame not aborted
        run_frame(100, 0, -1, 0, 1'b1, 1'b0, 1'b0, 0);
        run_frame(100, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0);

        // Bus error on word 2, then ack+err together on word 1
        run_frame(80, 1, 2, 1, 1'b0, 1'b0, 1'b0, 0);
        run_frame(100, 0, 1, 3, 1'b0, 1'b0, 1'b0, 0);
        run_frame(100, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0);

        // Start with enable low while idle
        @(negedge clk); #1;
        start  = 1'b1;
        enable = 1'b0;
        @(negedge clk); #1;
        start  = 1'b0;
        enable = 1'b1;
        check_eq("en_low_busy", 32'(busy), 32'd0);
        tvalid_seen = 0;
        repeat (10) @(negedge clk);
        #1;
        check_eq("en_low_no_frame", 32'(tvalid_seen), 32'd0);
        run_frame(100, 0, -1, 0, 1'b0, 1'b0, 1'b0, 0);

        // Asynchronous reset while presenting a payload word
        cfg_ready_pct = 100;
        cfg_max_wait  = 0;
        cfg_bad_word  = -1;
        @(negedge clk); #1;
        rx_q.delete();
        burst_cnt = 0;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.m_tvalid && !bus.wbm_cyc_o && rx_q.size() >= 2) begin
                found = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check_eq("found_out", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_tvalid", 32'(bus.m_tvalid), 32'd0);
        check_eq("arst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        check_eq("arst_stb", 32'(bus.wbm_stb_o), 32'd0);
        check_eq("arst_tdata", bus.m_tdata, 32'd0);
        check_eq("arst_tlast", 32'(bus.m_tlast), 32'd0);
        check_eq("arst_adr", 32'(bus.wbm_adr_o), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        @(negedge clk); #1;
        rst_n       = 1'b1;
        tvalid_seen = 0;
        model_seq   = 0;
        pend_missed = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check_eq("no_resume_busy", 32'(busy), 32'd0);
        check_eq("no_resume_valid", 32'(tvalid_seen), 32'd0);

        // Sequence wrap: 256 frames from reset, then one more with seq 00
        for (int k = 0; k < 257; k++) run_frame(85, 1, -1, 0, 1'b0, 1'b0, 1'b0, 0);

        // Ack timeout on word 0
`ifdef SCALER_READOUT_TIMEOUT_EN
        run_frame(100, 0, 0, 2, 1'b0, 1'b0, 1'b0, 0);
        check_eq("tmo_cyc_len", 32'(burst0_len), 32'd10);
`else
        cfg_bad_word = 0;
        cfg_bad_kind = 2;
        @(negedge clk); #1;
        burst_cnt = 0;
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        check_eq("no_tmo_busy", 32'(busy), 32'd1);
        check_eq("no_tmo_cyc", 32'(bus.wbm_cyc_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("no_tmo_rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
